// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int         UART_BYTE_W  = 8;
  localparam logic [3:0] UART_ID_MARK = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Searches from last_i+1 upward, wrapping modulo N; N need not be a power of two.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int cand;
    any_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_i) + i;
      if (cand >= N) cand = cand - N;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-granular round-robin arbiter in front of uart_tx
// Optionally prefixes each frame with {A, src} so the receiver can demultiplex.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter bit INSERT_ID    = 1'b1,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_SRC-1:0]             i_s_axis_tvalid,
  input  logic [UART_BYTE_W*N_SRC-1:0] i_s_axis_tdata,
  input  logic [N_SRC-1:0]             i_s_axis_tlast,
  output logic [N_SRC-1:0]             o_s_axis_tready,
  output logic                         o_m_axis_tvalid,
  output logic [UART_BYTE_W-1:0]       o_m_axis_tdata,
  input  logic                         i_m_axis_tready,
  output logic [3:0]                   o_grant_idx,
  output logic                         o_busy,
  output logic                         o_abort
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          src_valid, src_last, m_hs, timeout;

  rr_pick #(.N(N_SRC), .IW(GW)) u_rr_pick (
    .req_i  (i_s_axis_tvalid),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  assign src_valid = i_s_axis_tvalid[grant_q];
  assign src_last  = i_s_axis_tlast[grant_q];
  assign m_hs      = o_m_axis_tvalid & i_m_axis_tready;
  // Fires on the IDLE_TIMEOUT-th consecutive idle cycle; a live tvalid always wins.
  assign timeout   = (IDLE_TIMEOUT != 0) && (state_q == DATA) && !src_valid &&
                     (int'(idle_cnt_q) + 1 >= IDLE_TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(N_SRC - 1);
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = INSERT_ID ? HDR : DATA;
        end
      end
      HDR: begin
        if (m_hs) state_d = DATA;
      end
      DATA: begin
        if (src_valid) idle_cnt_d = '0;
        else if (int'(idle_cnt_q) < IDLE_TIMEOUT) idle_cnt_d = idle_cnt_q + CW'(1);
        if ((m_hs && src_last) || timeout) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so a byte in flight is never acknowledged during reset.
  always_comb begin
    o_s_axis_tready = '0;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tdata  = '0;
    o_abort         = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        HDR: begin
          o_m_axis_tvalid = 1'b1;
          o_m_axis_tdata  = {UART_ID_MARK, 4'(grant_q)};
        end
        DATA: begin
          o_m_axis_tvalid          = src_valid;
          o_m_axis_tdata           = i_s_axis_tdata[UART_BYTE_W*grant_q +: UART_BYTE_W];
          o_s_axis_tready[grant_q] = i_m_axis_tready;
          o_abort                  = timeout;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_grant_idx = 4'(grant_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  s_valid, s_last;
  logic [31:0] s_data;
  logic        m_ready;

  logic [3:0] a_rdy, a_gidx, b_gidx;
  logic [2:0] b_rdy;
  logic       a_mv, a_busy, a_abort, b_mv, b_busy, b_abort;
  logic [7:0] a_md, b_md;

  uart_tx_arbiter #(.N_SRC(4), .INSERT_ID(1'b1), .IDLE_TIMEOUT(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_axis_tvalid(s_valid), .i_s_axis_tdata(s_data), .i_s_axis_tlast(s_last),
    .o_s_axis_tready(a_rdy), .o_m_axis_tvalid(a_mv), .o_m_axis_tdata(a_md),
    .i_m_axis_tready(m_ready), .o_grant_idx(a_gidx), .o_busy(a_busy), .o_abort(a_abort)
  );

  uart_tx_arbiter #(.N_SRC(3), .INSERT_ID(1'b0), .IDLE_TIMEOUT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_axis_tvalid(s_valid[2:0]), .i_s_axis_tdata(s_data[23:0]), .i_s_axis_tlast(s_last[2:0]),
    .o_s_axis_tready(b_rdy), .o_m_axis_tvalid(b_mv), .o_m_axis_tdata(b_md),
    .i_m_axis_tready(m_ready), .o_grant_idx(b_gidx), .o_busy(b_busy), .o_abort(b_abort)
  );

  // Which instance is being scored, and its configuration
  bit   sel_b;
  int   n_src, tmo;
  bit   ins_id;
  logic [3:0] o_rdy, o_gidx;
  logic       o_mv, o_busy, o_abort;
  logic [7:0] o_md;

  always_comb begin
    o_rdy   = sel_b ? {1'b0, b_rdy} : a_rdy;
    o_mv    = sel_b ? b_mv : a_mv;
    o_md    = sel_b ? b_md : a_md;
    o_gidx  = sel_b ? b_gidx : a_gidx;
    o_busy  = sel_b ? b_busy : a_busy;
    o_abort = sel_b ? b_abort : a_abort;
  end

  // Sources: queued {tlast, byte} entries plus an inter-byte gap
  logic [8:0] fq[4][$];
  int         gap[4];
  int         max_gap, force_gap;
  bit         long_ok;

  // Reference: who owns the line, whether its header is still owed, fairness pointer
  int owner, lastg, idlec, gshow;
  bit hdr_due;

  logic [7:0] line[$];
  logic [7:0] expq[$];
  int         hs_cyc[$];
  int         cyc, abort_cyc, abort_n;
  int         ncmp, nfail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input int last, input int n, input logic [3:0] v);
    for (int d = 1; d <= n; d++)
      if (v[(last + d) % n]) return (last + d) % n;
    return -1;
  endfunction

  function automatic int pick_gap();
    if (force_gap > 0) return force_gap;
    if (long_ok && $urandom_range(0, 15) == 0) return 24;
    return $urandom_range(0, max_gap);
  endfunction

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      s_valid[k]       = (fq[k].size() > 0) && (gap[k] == 0);
      s_data[8*k +: 8] = (fq[k].size() > 0) ? fq[k][0][7:0] : 8'h00;
      s_last[k]        = (fq[k].size() > 0) ? fq[k][0][8] : 1'b0;
    end
  endtask

  task automatic drop_frame(input int k);
    logic [8:0] e;
    gap[k] = 0;
    while (fq[k].size() > 0) begin
      e = fq[k].pop_front();
      if (e[8]) break;
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input bit last);
    fq[k].push_back({last, b});
  endtask

  task automatic step();
    logic [3:0] e_rdy;
    logic       e_mv, e_ab;
    logic [7:0] e_md;
    int         w;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check("rst_tready", 32'(o_rdy), 32'h0);
      check("rst_tvalid", 32'(o_mv), 32'h0);
      owner = -1; hdr_due = 1'b0; lastg = n_src - 1; idlec = 0; gshow = 0;
    end else begin
      e_rdy = '0; e_mv = 1'b0; e_md = '0; e_ab = 1'b0;
      if (owner >= 0 && hdr_due) begin
        e_mv = 1'b1;
        e_md = {4'hA, 4'(owner)};
      end else if (owner >= 0) begin
        e_mv         = s_valid[owner];
        e_md         = s_data[8*owner +: 8];
        e_rdy[owner] = m_ready;
        e_ab         = !s_valid[owner] && tmo > 0 && (idlec + 1 == tmo);
      end
      check("tready", 32'(o_rdy), 32'(e_rdy));
      check("tvalid", 32'(o_mv), 32'(e_mv));
      if (e_mv) check("tdata", 32'(o_md), 32'(e_md));
      check("abort", 32'(o_abort), 32'(e_ab));
      check("busy", 32'(o_busy), 32'(owner >= 0));
      check("grant_idx", 32'(o_gidx), 32'(gshow));
      if (o_mv && m_ready) begin
        line.push_back(o_md);
        hs_cyc.push_back(cyc);
      end
      if (o_abort) begin
        abort_cyc = cyc;
        abort_n++;
      end
      if (owner < 0) begin
        w = rr_next(lastg, n_src, s_valid);
        if (w >= 0) begin
          owner = w; gshow = w; hdr_due = ins_id; idlec = 0;
        end
      end else if (hdr_due) begin
        if (m_ready) hdr_due = 1'b0;
      end else if (s_valid[owner]) begin
        idlec = 0;
        if (m_ready && s_last[owner]) begin
          lastg = owner; owner = -1;
        end
      end else if (e_ab) begin
        lastg = owner; owner = -1;
      end else begin
        idlec++;
      end
      for (int k = 0; k < 4; k++) begin
        if (gap[k] > 0) gap[k]--;
        if (s_valid[k] && o_rdy[k]) begin
          void'(fq[k].pop_front());
          gap[k] = pick_gap();
        end
      end
      if (o_abort) drop_frame(int'(o_gidx[1:0]));
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) begin
      fq[k].delete();
      gap[k] = 0;
    end
    drive();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    line.delete();
    hs_cyc.delete();
    abort_n = 0;
  endtask

  task automatic check_line(input string tag);
    check({tag, "_len"}, line.size(), expq.size());
    for (int i = 0; i < expq.size() && i < line.size(); i++)
      check(tag, 32'(line[i]), 32'(expq[i]));
  endtask

  task automatic random_phase(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < n_src; k++) begin
        if (fq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 5);
          for (int j = 0; j < len; j++)
            push(k, 8'($urandom_range(0, 255)), j == len - 1);
        end
      end
      drive();
      step();
    end
  endtask

  initial begin
    ncmp = 0; nfail = 0; cyc = 0; abort_cyc = 0; abort_n = 0;
    sel_b = 1'b0; n_src = 4; ins_id = 1'b1; tmo = 16;
    max_gap = 0; force_gap = 0; long_ok = 1'b0;
    owner = -1; lastg = 3; idlec = 0; gshow = 0; hdr_due = 1'b0;
    rst_n = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) gap[k] = 0;
    drive();

    // Single frame from source 1 with its header
    do_reset();
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1); drive();
    run(8);
    expq = '{8'hA1, 8'h11, 8'h22};
    check_line("frame_src1");

    // Three simultaneous one-byte frames, twice: order must repeat
    do_reset();
    push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1); push(2, 8'h32, 1'b1); drive();
    run(12);
    push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1); push(2, 8'h32, 1'b1); drive();
    run(12);
    expq = '{8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32, 8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32};
    check_line("rotation");

    // Source 3 streams 4-byte frames; source 0 slips in between, never mid-frame
    do_reset();
    for (int i = 0; i < 12; i++) push(3, 8'(8'hC0 + i), (i % 4) == 3);
    drive();
    run(2);
    push(0, 8'h0F, 1'b1); drive();
    run(40);
    expq = '{8'hA3, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA0, 8'h0F,
             8'hA3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hA3, 8'hC8, 8'hC9, 8'hCA, 8'hCB};
    check_line("no_split");

    // Source 2 stalls after one byte; timeout aborts and source 3 goes next
    do_reset();
    force_gap = 100;
    push(2, 8'h55, 1'b0); push(2, 8'h56, 1'b1); push(3, 8'h77, 1'b1); drive();
    run(30);
    force_gap = 0;
    expq = '{8'hA2, 8'h55, 8'hA3, 8'h77};
    check_line("timeout");
    check("abort_count", abort_n, 1);
    if (hs_cyc.size() > 1) check("abort_delay", abort_cyc - hs_cyc[1], 16);
    else check("abort_hs_seen", hs_cyc.size(), 2);

    // Reset mid-frame of source 0: unaccepted bytes are re-sent, source 0 first
    do_reset();
    push(0, 8'h40, 1'b0); push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1); push(1, 8'h50, 1'b1); drive();
    run(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(12);
    expq = '{8'hA0, 8'h40, 8'hA0, 8'h41, 8'h42, 8'hA1, 8'h50};
    check_line("mid_reset");

    // Random traffic on the 4-source, header, timeout instance
    do_reset();
    max_gap = 2; long_ok = 1'b1;
    random_phase(2000);
    max_gap = 0; long_ok = 1'b0;

    // 3-source instance without headers: wrap 2 -> 0 and 2-cycle frame gap
    sel_b = 1'b1; n_src = 3; ins_id = 1'b0; tmo = 0;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(k, 8'(8'h30 + k), 1'b1);
      push(k, 8'(8'h33 + k), 1'b1);
    end
    drive();
    run(16);
    expq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    check_line("wrap_n3");
    for (int i = 1; i < hs_cyc.size(); i++) check("frame_gap", hs_cyc[i] - hs_cyc[i-1], 2);

    // Random traffic on the 3-source instance, long stalls never abort
    do_reset();
    max_gap = 2; long_ok = 1'b1;
    random_phase(2000);
    check("no_abort_n3", abort_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
